// File: rtl/scan_pkg.sv
// rtl/scan_pkg.sv - shared types and constants for the digit scan controller
//
// Purpose : FSM state type and nibble width used by digit_scan_ctrl.
// Ports   : none (package).
package scan_pkg;

  localparam int NIBBLE_W = 4;

  // GUARD keeps the segments dark at the start of a slot so the previous
  // digit's pattern never ghosts onto the newly selected anode.
  typedef enum logic {
    GUARD = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

endpackage

// File: rtl/digit_scan_ctrl_tick_gen.sv
// rtl/digit_scan_ctrl_tick_gen.sv - slot prescaler producing one tick per digit slot
//
// Purpose : counts 0..PRESCALE-1 while enabled and flags the last cycle of a slot.
// Ports   :
//   clk      in   system clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   enable   in   1 = count, 0 = hold
//   tick     out  1 on the last cycle of each slot (only while enabled)
module tick_gen #(
  parameter int PRESCALE = 100000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  output logic tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [CW-1:0] count;

  // Decoded from the registered count so the pulse is glitch-free and
  // lines up with the cycle that closes the slot.
  assign tick = enable && (count == CW'(PRESCALE - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (enable) begin
      count <= tick ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/digit_scan_ctrl.sv
// rtl/digit_scan_ctrl.sv - time-multiplexed scan controller for an N-digit 7-segment display
//
// Purpose : steps a digit index once per slot, presents that digit's nibble
//           from a per-frame shadow copy of data_in, and blanks the segments
//           during a guard interval at the start of every slot.
// Option  : define SCAN_LZ_BLANK_EN to also blank leading zero digits.
// Ports   :
//   clk         in   system clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   enable      in   1 = scan, 0 = freeze and blank
//   data_in     in   digit nibbles, digit k = data_in[4k+3:4k]
//   digit_idx   out  current digit index (drives decoder_nbit)
//   digit_val   out  nibble of the current digit from the shadow register
//   blank       out  1 = segments must be off
//   digit_tick  out  one-cycle pulse on the last cycle of each slot
module digit_scan_ctrl
  import scan_pkg::*;
#(
  parameter int N_DIGITS  = 8,
  parameter int IDX_W     = $clog2(N_DIGITS),
  parameter int PRESCALE  = 100000,
  parameter int BLANK_CYC = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         enable,
  input  logic [NIBBLE_W*N_DIGITS-1:0] data_in,
  output logic [IDX_W-1:0]             digit_idx,
  output logic [NIBBLE_W-1:0]          digit_val,
  output logic                         blank,
  output logic                         digit_tick
);

  localparam int GW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic                         tick;
  logic                         last_digit;
  logic                         lz_blank;
  logic [NIBBLE_W*N_DIGITS-1:0] shadow;
  logic [GW-1:0]                guard_cnt;
  scan_state_t                  state;

  tick_gen #(
    .PRESCALE (PRESCALE)
  ) u_tick_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (enable),
    .tick    (tick)
  );

  assign digit_tick = tick;
  assign last_digit = (digit_idx == IDX_W'(N_DIGITS - 1));

  // Index wraps explicitly at N_DIGITS-1 so non-power-of-two digit counts
  // never present an index the anode decoder has no digit for.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      digit_idx <= '0;
      shadow    <= '0;
      state     <= GUARD;
      guard_cnt <= '0;
    end else if (enable) begin
      if (tick) begin
        digit_idx <= last_digit ? '0 : digit_idx + IDX_W'(1);
        // Whole-frame snapshot: every digit of the next frame comes from
        // this single sample, so mid-frame data changes never tear.
        if (last_digit) begin
          shadow <= data_in;
        end
        state     <= (BLANK_CYC == 0) ? SHOW : GUARD;
        guard_cnt <= '0;
      end else if (state == GUARD) begin
        if (BLANK_CYC == 0 || guard_cnt == GW'(BLANK_CYC - 1)) begin
          state <= SHOW;
        end
        guard_cnt <= guard_cnt + GW'(1);
      end
    end
  end

  always_comb begin
    digit_val = '0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (digit_idx == IDX_W'(k)) begin
        digit_val = shadow[k*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

`ifdef SCAN_LZ_BLANK_EN
  // A digit is a leading zero when it and every more significant digit of
  // the shadow frame are zero; digit 0 always shows so "0" stays visible.
  logic upper_nz;

  always_comb begin
    upper_nz = 1'b0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if ((IDX_W'(k) >= digit_idx) && (shadow[k*NIBBLE_W +: NIBBLE_W] != '0)) begin
        upper_nz = 1'b1;
      end
    end
    lz_blank = (digit_idx != '0) && !upper_nz;
  end
`else
  assign lz_blank = 1'b0;
`endif

  assign blank = !enable || (state == GUARD) || lz_blank;

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// tb/tb_digit_scan_ctrl.sv - self-checking bench for digit_scan_ctrl
module tb_digit_scan_ctrl;

  localparam int N_DIGITS = 3;
  localparam int IDX_W    = 2;
  localparam int PRESCALE = 4;

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic [11:0] data_in;

  logic [1:0]  digit_idx,  digit_idx0;
  logic [3:0]  digit_val,  digit_val0;
  logic        blank,      blank0;
  logic        digit_tick, digit_tick0;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state: enabled edges since reset and expected shadow
  int          e;
  logic [11:0] m_shadow;

  digit_scan_ctrl #(
    .N_DIGITS (N_DIGITS), .IDX_W (IDX_W), .PRESCALE (PRESCALE), .BLANK_CYC (1)
  ) dut (
    .clk (clk), .reset_n (reset_n), .enable (enable), .data_in (data_in),
    .digit_idx (digit_idx), .digit_val (digit_val), .blank (blank), .digit_tick (digit_tick)
  );

  digit_scan_ctrl #(
    .N_DIGITS (N_DIGITS), .IDX_W (IDX_W), .PRESCALE (PRESCALE), .BLANK_CYC (0)
  ) dut0 (
    .clk (clk), .reset_n (reset_n), .enable (enable), .data_in (data_in),
    .digit_idx (digit_idx0), .digit_val (digit_val0), .blank (blank0), .digit_tick (digit_tick0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic logic lz_exp(input int idx, input logic [11:0] sh);
`ifdef SCAN_LZ_BLANK_EN
    return (idx > 0) && ((sh >> (4 * idx)) == 12'h000);
`else
    return 1'b0;
`endif
  endfunction

  task automatic check_reset_values();
    check("rst_idx",    32'(digit_idx),   32'd0);
    check("rst_val",    32'(digit_val),   32'd0);
    check("rst_blank",  32'(blank),       32'd1);
    check("rst_tick",   32'(digit_tick),  32'd0);
    check("rst_idx0",   32'(digit_idx0),  32'd0);
    check("rst_blank0", 32'(blank0),      32'd1);
    check("rst_tick0",  32'(digit_tick0), 32'd0);
  endtask

  // compare every output of both instances against the model
  task automatic cycle_checks();
    int  idx;
    logic [3:0] val;
    logic lz;
    idx = (e / PRESCALE) % N_DIGITS;
    val = m_shadow[4*idx +: 4];
    lz  = lz_exp(idx, m_shadow);
    check("idx",       32'(digit_idx),  32'(idx));
    check("idx_range", 32'(digit_idx < 2'd3), 32'd1);
    check("val",       32'(digit_val),  32'(val));
    check("tick",      32'(digit_tick), 32'(enable && (e % PRESCALE == PRESCALE - 1)));
    check("blank",     32'(blank),      32'(!enable || (e % PRESCALE == 0) || lz));
    check("idx0",      32'(digit_idx0), 32'(idx));
    check("blank0",    32'(blank0),     32'(!enable || (e == 0) || lz));
  endtask

  // advance the model across the coming clock edge
  task automatic model_edge();
    if (enable) begin
      if ((e % PRESCALE == PRESCALE - 1) && ((e / PRESCALE) % N_DIGITS == N_DIGITS - 1))
        m_shadow = data_in;
      e++;
    end
  endtask

  initial begin
    reset_n = 1'b0;
    enable  = 1'b0;
    data_in = 12'h321;
    #3;
    check_reset_values();

    // scan, wrap, guard, mid-frame data change, enable hold, async reset
    enable = 1'b1;
    @(negedge clk);
    reset_n  = 1'b1;
    e        = 0;
    m_shadow = 12'h000;
    for (int c = 0; c < 90; c++) begin
      #1;
      cycle_checks();
      if (e == 64) begin
        // mid-GUARD of idx 1: reset must act before the next clock edge
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_values();
        break;
      end
      if (c == 29) begin
        check("chg_at_idx1", 32'(digit_idx), 32'd1);
        data_in = 12'h654;
      end
      if (c == 49) enable = 1'b0;
      if (c == 59) enable = 1'b1;
      model_edge();
      @(negedge clk);
    end
    check("reset_reached", 32'(e), 32'd64);

    // leading-zero run with data 005
    data_in = 12'h005;
    @(negedge clk);
    reset_n  = 1'b1;
    e        = 0;
    m_shadow = 12'h000;
    for (int c = 0; c < 24; c++) begin
      #1;
      cycle_checks();
      model_edge();
      @(negedge clk);
    end
    #1;
    // frame 2, idx 0, pres 0: digit 0 always shown once loaded
    check("lz_idx0_val", 32'(digit_val), 32'h5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
